// File: rtl/mtr_drv_pwm_if.sv
// Bundle between the balance controller and the motor-drive back end:
// per-wheel speed/direction commands in, H-bridge pins and period strobe out.
interface mtr_drv_pwm_if #(
  parameter int CNT_W = 11
);
  logic             pwr_up;
  logic [CNT_W-1:0] lft_spd;
  logic             lft_rev;
  logic [CNT_W-1:0] rght_spd;
  logic             rght_rev;
  logic             lft_fwd;
  logic             lft_rvs;
  logic             rght_fwd;
  logic             rght_rvs;
  logic             prd_strt;

  modport master (
    output pwr_up, lft_spd, lft_rev, rght_spd, rght_rev,
    input  lft_fwd, lft_rvs, rght_fwd, rght_rvs, prd_strt
  );

  modport slave (
    input  pwr_up, lft_spd, lft_rev, rght_spd, rght_rev,
    output lft_fwd, lft_rvs, rght_fwd, rght_rvs, prd_strt
  );
endinterface

// File: rtl/mtr_drv_pwm.sv
// Dual-wheel edge-aligned PWM with period-synchronous duty update and dead-time
// insertion on direction reversal. Optional bridge brake on zero duty: MTR_DRV_BRAKE_EN.
module mtr_drv_pwm #(
  parameter int CNT_W    = 11,
  parameter int DEAD_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mtr_drv_pwm_if.slave  bus
);

  typedef enum logic [1:0] {FWD, REV, DEAD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] DEAD_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             prd_load;
  logic             prd_q;

  logic [CNT_W-1:0] spd_in  [2];
  logic             rev_in  [2];
  logic [CNT_W-1:0] duty_sh [2];
  logic             dir_sh  [2];

  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] dead_q  [2];
  logic [CNT_W-1:0] dead_d  [2];

  logic             pwm     [2];
  logic             fwd_d   [2];
  logic             rvs_d   [2];
  logic             fwd_q   [2];
  logic             rvs_q   [2];

  assign spd_in[0] = bus.lft_spd;
  assign rev_in[0] = bus.lft_rev;
  assign spd_in[1] = bus.rght_spd;
  assign rev_in[1] = bus.rght_rev;

  // The last count of each period is the only point where new commands are accepted.
  assign prd_load = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      prd_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        duty_sh[i] <= '0;
        dir_sh[i]  <= 1'b0;
      end
    end else begin
      cnt   <= cnt + 1'b1;
      prd_q <= prd_load;
      if (prd_load) begin
        for (int i = 0; i < 2; i++) begin
          duty_sh[i] <= spd_in[i];
          dir_sh[i]  <= rev_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= FWD;
        dead_q[i]  <= '0;
        fwd_q[i]   <= 1'b0;
        rvs_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        dead_q[i]  <= dead_d[i];
        fwd_q[i]   <= fwd_d[i];
        rvs_q[i]   <= rvs_d[i];
      end
    end
  end

  // DEAD always runs its full length; the exit direction is whatever the shadow holds then.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      dead_d[i]  = dead_q[i];
      fwd_d[i]   = 1'b0;
      rvs_d[i]   = 1'b0;
      pwm[i]     = (cnt < duty_sh[i]);

      unique case (state_q[i])
        FWD: begin
          fwd_d[i] = pwm[i];
          if (prd_load && rev_in[i]) begin
            state_d[i] = DEAD;
            dead_d[i]  = DEAD_LD;
          end
        end
        REV: begin
          rvs_d[i] = pwm[i];
          if (prd_load && !rev_in[i]) begin
            state_d[i] = DEAD;
            dead_d[i]  = DEAD_LD;
          end
        end
        DEAD: begin
          if (dead_q[i] > DEAD_ONE) begin
            dead_d[i] = dead_q[i] - 1'b1;
          end else begin
            dead_d[i]  = '0;
            state_d[i] = dir_sh[i] ? REV : FWD;
          end
        end
        default: begin
          state_d[i] = FWD;
          dead_d[i]  = '0;
        end
      endcase

`ifdef MTR_DRV_BRAKE_EN
      if ((state_q[i] != DEAD) && (duty_sh[i] == '0)) begin
        fwd_d[i] = 1'b1;
        rvs_d[i] = 1'b1;
      end
`endif

      fwd_d[i] = fwd_d[i] & bus.pwr_up;
      rvs_d[i] = rvs_d[i] & bus.pwr_up;
    end
  end

  assign bus.lft_fwd  = fwd_q[0];
  assign bus.lft_rvs  = rvs_q[0];
  assign bus.rght_fwd = fwd_q[1];
  assign bus.rght_rvs = rvs_q[1];
  assign bus.prd_strt = prd_q;

endmodule

// File: doc/mtr_drv_pwm.md
Name: mtr_drv_pwm

Overview:
- Motor-drive back end for balance_cntrl.
- Consumes the per-wheel magnitude/direction outputs (lft_spd/lft_rev, rght_spd/rght_rev) and produces the H-bridge control pins for both motors.
- Per wheel: an 11-bit edge-aligned PWM with period-synchronous duty update, plus a direction state machine that inserts dead time on every direction reversal.

Parameters:
- CNT_W, 11, PWM counter width. Must equal the spd width. Period is 2^CNT_W clocks.
- DEAD_CYC, 64, dead-time length in clocks on a direction change. Legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pwr_up  input  1  drive enable; low forces all bridge outputs low
- lft_spd  input  CNT_W  left duty magnitude
- lft_rev  input  1  left direction, 1 = reverse
- rght_spd  input  CNT_W  right duty magnitude
- rght_rev  input  1  right direction, 1 = reverse
- lft_fwd  output  1  left bridge forward input
- lft_rvs  output  1  left bridge reverse input
- rght_fwd  output  1  right bridge forward input
- rght_rvs  output  1  right bridge reverse input
- prd_strt  output  1  one-clock pulse in the cycle the counter equals 0

Behaviour:
- Reset (asynchronous, active-low): counter = 0, duty shadows = 0, direction shadows = 0, both FSMs = FWD, dead counters = 0, all outputs = 0.
- Counter: free-running CNT_W-bit, +1 every clock, wraps 2^CNT_W-1 -> 0 with no stall.
- Shadow load: in the cycle counter == 2^CNT_W-1, each wheel's spd/rev is captured into its shadow registers. Input changes at any other time have no effect until the next wrap.
- Raw PWM: pwm = (counter < duty_shadow), unsigned compare.
  - duty 0 -> never high.
  - duty 2^CNT_W-1 -> high for 2047 of 2048 clocks.
- Outputs are registered: one clock latency from counter to pin.
- Per-wheel FSM states: FWD, REV, DEAD.
  - FWD/REV: active pin = pwm, other pin = 0.
  - FWD/REV: on a shadow load whose dir differs from the current state, go to DEAD and load the dead counter with DEAD_CYC.
  - DEAD: both pins 0; dead counter decrements each clock.
  - DEAD: when the dead counter reaches 0, enter FWD if dir shadow = 0, else REV. The PWM compare resumes mid-period from the current counter value.
  - A reversal back to the original direction while in DEAD is latched and honoured on DEAD exit (DEAD still completes in full).
  - Left and right FSMs are fully independent.
- fwd and rvs of the same wheel are never both 1 (except brake, see Optional Feature).
- pwr_up low:
  - All four pins are 0 from the next clock edge.
  - Counter, shadows and FSMs keep running.
  - When pwr_up returns high, the pins resume from the current state on the next edge.
- prd_strt is registered, asserted while counter == 0, and is unaffected by pwr_up.
- Reset asserted mid-period: all outputs low immediately (asynchronous). After release the counter restarts at 0 and the first shadow load occurs 2^CNT_W-1 clocks later.

Optional Feature:
- Macro: MTR_DRV_BRAKE_EN.
- Defined: in FWD or REV with duty shadow == 0 and pwr_up = 1, both fwd and rvs of that wheel are driven 1 (bridge brake). DEAD state and pwr_up low still force both pins 0.
- Undefined: duty 0 drives both pins 0 (coast).

Test Plan:
- Duty update: reset, lft_spd = 0x200, lft_rev = 0 held -> first period all pins 0. From the next period, lft_fwd is high exactly 512 clocks per 2048 and lft_rvs = 0 throughout.
- Mid-period change: change lft_spd to 0x400 at counter 100 -> duty stays 512 for the remainder of that period; 1024 from the following prd_strt.
- Reversal with dead time: rght_spd = 0x7FF steady; toggle rght_rev 0 -> 1 -> rght_fwd low right after the wrap, both pins 0 for DEAD_CYC = 64 clocks, then rght_rvs high; rght_fwd and rght_rvs never both 1.
- Extremes: duty 0 -> pin never high (all 0, or both 1 with MTR_DRV_BRAKE_EN). Duty 0x7FF -> pin low exactly 1 clock per period.
- pwr_up: drop pwr_up for 300 clocks mid-period -> all pins 0 from the next edge while prd_strt keeps pulsing every 2048 clocks; output resumes within 1 clock of pwr_up high.
- Reset during DEAD: assert rst_n low while in DEAD -> outputs 0 asynchronously. After release, FSM = FWD and counter = 0; the new duty/direction take effect only after the first wrap.
